debounce_counter_array: RTL and testbench

//  NUM_CH-channel pushbutton front end: per channel, synchronise an active-low raw button,

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 123 ++++++++++++
 rtl/debounce_counter_array.sv | 47 ++++
 tb/tb_debounce_counter_array.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the pushbutton debounce/count front end.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } deb_state_t;

    // Counter step: at max either hold (sat) or wrap to zero.
    function automatic logic [31:0] cnt_inc(
        input logic [31:0] val,
        input logic [31:0] max,
        input logic        sat
    );
        if (val == max) begin
            return sat ? val : 32'd0;
        end
        return val + 32'd1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stable-time debounce FSM,
// raw edge detect and the clean/raw event counters.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_WIDTH       = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit SATURATE        = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_n,
    input  logic                 clear,
    output logic                 press_pulse,
    output logic                 release_pulse,
    output logic                 held,
    output logic [CNT_WIDTH-1:0] clean_count,
    output logic [CNT_WIDTH-1:0] raw_count
);

    localparam int TW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    logic          s0;
    logic          s1;
    logic          s1_d;
    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          press_nxt;
    logic          release_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s1_d <= 1'b0;
        end else begin
            s0   <= ~btn_n;
            s1   <= s0;
            s1_d <= s1;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (s1) begin
                    state_nxt = PRESS_WAIT;
                    timer_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s1) begin
                    state_nxt = IDLE;
                end else if (timer == T_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            HELD: begin
                if (!s1) begin
                    state_nxt = REL_WAIT;
                    timer_nxt = '0;
                end
            end
            REL_WAIT: begin
                if (s1) begin
                    state_nxt = HELD;
                end else if (timer == T_LAST) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    assign held = (state == HELD) || (state == REL_WAIT);

    // Clear outranks any increment landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            clean_count <= '0;
            raw_count   <= '0;
        end else begin
            if (press_pulse) begin
                clean_count <= CNT_WIDTH'(cnt_inc(32'(clean_count),
                                                  CNT_MAX, SATURATE));
            end
            if (s1 && !s1_d) begin
                raw_count <= raw_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/debounce_counter_array.sv
// NUM_CH independent debounced button channels with press and raw-edge
// counters packed onto flat buses, optionally inverted for active-low LEDs.
module debounce_counter_array
    import debounce_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CNT_WIDTH       = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SATURATE        = 0,
    parameter int OUT_INVERT      = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           btn_n,
    input  logic                        clear,
    output logic [NUM_CH-1:0]           press_pulse,
    output logic [NUM_CH-1:0]           release_pulse,
    output logic [NUM_CH-1:0]           held,
    output logic [NUM_CH*CNT_WIDTH-1:0] clean_count,
    output logic [NUM_CH*CNT_WIDTH-1:0] raw_count
);

    logic [NUM_CH*CNT_WIDTH-1:0] clean_vec;
    logic [NUM_CH*CNT_WIDTH-1:0] raw_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_WIDTH       (CNT_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SATURATE        (SATURATE != 0)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn_n         (btn_n[i]),
            .clear         (clear),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .held          (held[i]),
            .clean_count   (clean_vec[i*CNT_WIDTH +: CNT_WIDTH]),
            .raw_count     (raw_vec[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign clean_count = (OUT_INVERT != 0) ? ~clean_vec : clean_vec;
    assign raw_count   = (OUT_INVERT != 0) ? ~raw_vec   : raw_vec;

endmodule

// File: tb/tb_debounce_counter_array.sv
// Bench for debounce_counter_array: wrap/true-output and saturate/inverted
// instances side by side against a stable-run-length reference model.
module tb_debounce_counter_array;

    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int DC  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NCH-1:0]      btn_n;
    logic                clear;

    logic [NCH-1:0]      press_a, rel_a, held_a;
    logic [NCH*CW-1:0]   clean_a, raw_a;
    logic [NCH-1:0]      press_b, rel_b, held_b;
    logic [NCH*CW-1:0]   clean_b, raw_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounce_counter_array #(
        .NUM_CH(NCH), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DC),
        .SATURATE(0), .OUT_INVERT(0)
    ) dut_a (
        .clk(clk), .reset(reset), .btn_n(btn_n), .clear(clear),
        .press_pulse(press_a), .release_pulse(rel_a), .held(held_a),
        .clean_count(clean_a), .raw_count(raw_a)
    );

    debounce_counter_array #(
        .NUM_CH(NCH), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DC),
        .SATURATE(1), .OUT_INVERT(1)
    ) dut_b (
        .clk(clk), .reset(reset), .btn_n(btn_n), .clear(clear),
        .press_pulse(press_b), .release_pulse(rel_b), .held(held_b),
        .clean_count(clean_b), .raw_count(raw_b)
    );

    // Reference model: a debounced level flips once the synchronised
    // sample has disagreed with it for DC+1 consecutive clocks.
    bit       ms0 [NCH];
    bit       ms1 [NCH];
    bit       ms1d[NCH];
    bit       lvl [NCH];
    int       run [NCH];
    int       ca  [NCH];
    int       cb  [NCH];
    int       rc  [NCH];
    logic [NCH-1:0] mp, mr;

    always @(posedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (reset) begin
                ms0[ch] = 0; ms1[ch] = 0; ms1d[ch] = 0; lvl[ch] = 0;
                run[ch] = 0; ca[ch] = 0; cb[ch] = 0; rc[ch] = 0;
                mp[ch] = 0; mr[ch] = 0;
            end else begin
                if (clear) begin
                    ca[ch] = 0; cb[ch] = 0; rc[ch] = 0;
                end else begin
                    if (mp[ch]) begin
                        ca[ch] = (ca[ch] + 1) % 16;
                        cb[ch] = (cb[ch] == 15) ? 15 : cb[ch] + 1;
                    end
                    if (ms1[ch] && !ms1d[ch]) rc[ch] = (rc[ch] + 1) % 16;
                end
                mp[ch] = 0;
                mr[ch] = 0;
                if (ms1[ch] != lvl[ch]) begin
                    run[ch]++;
                    if (run[ch] == DC + 1) begin
                        lvl[ch] = ms1[ch];
                        run[ch] = 0;
                        if (ms1[ch]) mp[ch] = 1; else mr[ch] = 1;
                    end
                end else begin
                    run[ch] = 0;
                end
                ms1d[ch] = ms1[ch];
                ms1[ch]  = ms0[ch];
                ms0[ch]  = ~btn_n[ch];
            end
        end
    end

    function automatic logic [43:0] expv();
        logic [7:0] eca, ecb, erc;
        logic [1:0] ml;
        for (int ch = 0; ch < NCH; ch++) begin
            eca[ch*4 +: 4] = 4'(ca[ch]);
            ecb[ch*4 +: 4] = 4'(cb[ch]);
            erc[ch*4 +: 4] = 4'(rc[ch]);
            ml[ch] = lvl[ch];
        end
        return {mp, mr, ml, mp, mr, ml, eca, erc, ~ecb, ~erc};
    endfunction

    function automatic logic [43:0] obsv();
        return {press_a, rel_a, held_a, press_b, rel_b, held_b,
                clean_a, raw_a, clean_b, raw_b};
    endfunction

    task automatic cyc(input logic [1:0] b, input logic c);
        btn_n = b;
        clear = c;
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (12) cyc(2'b11, 1'b0);
        cyc(2'b11, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc(2'b11, 1'b0);
        reset = 1'b0;
        checks++;
        if ({press_a, rel_a, held_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {press_a, rel_a, held_a});
        end
        checks++;
        if ({clean_a, raw_a} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt_a got %h want 0000", {clean_a, raw_a});
        end
        checks++;
        if ({clean_b, raw_b} !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_cnt_b got %h want ffff", {clean_b, raw_b});
        end
    endtask

    task automatic test_press_latency();
        for (int k = 0; k <= 8; k++) begin
            cyc(2'b10, 1'b0);
            checks++;
            if (press_a !== {1'b0, k == 6}) begin
                errors++;
                $display("FAIL latency_press edge %0d got %b want %b",
                         k, press_a, {1'b0, k == 6});
            end
            if (k == 7) begin
                checks++;
                if (clean_a !== 8'h01) begin
                    errors++;
                    $display("FAIL latency_count got %h want 01", clean_a);
                end
            end
        end
        checks++;
        if (held_a !== 2'b01 || obsv() !== expv()) begin
            errors++;
            $display("FAIL latency_held got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_bounce();
        int lv[6] = '{0, 1, 0, 1, 0, 1};
        int nc[6] = '{1, 2, 11, 1, 2, 12};
        int np = 0;
        int nr = 0;
        settle();
        for (int s = 0; s < 6; s++) begin
            for (int n = 0; n < nc[s]; n++) begin
                cyc({1'b1, 1'(lv[s])}, 1'b0);
                np += int'(press_a[0]);
                nr += int'(rel_a[0]);
            end
            if (s == 2) begin
                checks++;
                if (raw_a[3:0] !== 4'd2 || clean_a[3:0] !== 4'd1 || np != 1) begin
                    errors++;
                    $display("FAIL bounce_press got raw=%0d clean=%0d np=%0d want 2 1 1",
                             raw_a[3:0], clean_a[3:0], np);
                end
            end
        end
        checks++;
        if (nr != 1 || held_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release got nr=%0d held=%b want 1 0",
                     nr, held_a[0]);
        end
        checks++;
        if (obsv() !== expv()) begin
            errors++;
            $display("FAIL bounce_model got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_glitch();
        int np = 0;
        settle();
        repeat (3) cyc(2'b01, 1'b0);
        repeat (10) begin
            cyc(2'b11, 1'b0);
            np += int'(press_a[1]);
        end
        checks++;
        if (np != 0 || clean_a[7:4] !== 4'd0 || raw_a[7:4] !== 4'd1) begin
            errors++;
            $display("FAIL glitch got np=%0d clean=%0d raw=%0d want 0 0 1",
                     np, clean_a[7:4], raw_a[7:4]);
        end
    endtask

    task automatic test_wrap();
        settle();
        repeat (17) begin
            repeat (8) cyc(2'b10, 1'b0);
            repeat (8) cyc(2'b11, 1'b0);
        end
        checks++;
        if (clean_a[3:0] !== 4'd1 || raw_a[3:0] !== 4'd1) begin
            errors++;
            $display("FAIL wrap got clean=%0d raw=%0d want 1 1",
                     clean_a[3:0], raw_a[3:0]);
        end
        checks++;
        if (clean_b[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL saturate got %h want 0 (inverted 15)", clean_b[3:0]);
        end
        checks++;
        if (obsv() !== expv()) begin
            errors++;
            $display("FAIL wrap_model got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_clear_collide();
        bit seen = 0;
        settle();
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc(2'b10, 1'b0);
            seen = press_a[0];
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL clear_press_timeout got 0 want 1");
        end
        cyc(2'b10, 1'b1);
        checks++;
        if (clean_a[3:0] !== 4'd0 || clean_b[3:0] !== 4'hF) begin
            errors++;
            $display("FAIL clear_collide got a=%h b=%h want 0 f",
                     clean_a[3:0], clean_b[3:0]);
        end
        cyc(2'b10, 1'b0);
        checks++;
        if (obsv() !== expv()) begin
            errors++;
            $display("FAIL clear_model got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        cyc(2'b10, 1'b0);
        checks++;
        if ({press_a, rel_a, held_a, clean_a, raw_a, clean_b, raw_b} !==
            {6'b0, 16'h0000, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset_mid got %h want %h",
                     {press_a, rel_a, held_a, clean_a, raw_a, clean_b, raw_b},
                     {6'b0, 16'h0000, 16'hFFFF});
        end
        reset = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            cyc(2'b10, 1'b0);
            checks++;
            if (press_a[0] !== (k == 6)) begin
                errors++;
                $display("FAIL reset_repress edge %0d got %b want %b",
                         k, press_a[0], k == 6);
            end
        end
        checks++;
        if (clean_a[3:0] !== 4'd1 || clean_b[3:0] !== 4'b1110) begin
            errors++;
            $display("FAIL reset_recount got a=%h b=%b want 1 1110",
                     clean_a[3:0], clean_b[3:0]);
        end
    endtask

    task automatic test_random();
        int left[2] = '{0, 0};
        logic [1:0] b = 2'b11;
        logic c;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (left[ch] == 0) begin
                    b[ch] = ~b[ch];
                    left[ch] = $urandom_range(1, 9);
                end
                left[ch]--;
            end
            c = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) == 0);
            cyc(b, c);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL random cycle %0d got %h want %h",
                         i, obsv(), expv());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        btn_n = 2'b11;
        clear = 1'b0;
        test_reset();
        test_press_latency();
        test_bounce();
        test_glitch();
        test_wrap();
        test_clear_collide();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
